uart_rx_ctrl: RTL and testbench



---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_fifo.sv | 69 ++++++
 rtl/uart_rx_ctrl.sv | 151 +++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared register map, bit positions and defaults for the UART receive controller.
package uart_pkg;

  typedef enum logic [1:0] {REG_DATA, REG_STATUS, REG_CTRL, REG_DIV} uart_reg_e;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_SNUM_BIT   = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;
  localparam int CTRL_FLUSH_BIT  = 3;

  localparam int STAT_NOT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT      = 1;
  localparam int STAT_OVERRUN_BIT   = 2;
  localparam int STAT_RXING_BIT     = 3;
  localparam int STAT_COUNT_LSB     = 8;

  localparam int DATA_VALID_BIT = 8;

  // 50 MHz / (16 * 115200) - 1
  localparam int UART_DIV_RESET = 26;

endpackage

// File: rtl/uart_rx_fifo.sv
// Circular byte buffer for received characters with push/pop/flush and occupancy count.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [7:0]    data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [7:0]    head_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [CW-1:0] count_o,
  output logic [CW-1:0] count_next_o,
  output logic          drop_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & ~flush_i & (~full_o | do_pop);
  assign drop_o  = push_i & ~flush_i & full_o & ~do_pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o       = mem_q[rd_ptr_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Bus-mapped UART receive controller: baud tick generator, stop-bit select,
// byte capture on rx_done rising edge into a FIFO, status and interrupt.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int DIV_W     = 16,
  parameter int DIV_RESET = UART_DIV_RESET
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [7:0]  d_rx,
  input  logic        rx_done,
  input  logic        rxing,
  output logic        tick,
  output logic        snum,
  output logic        irq
);

  localparam int CW = $clog2(DEPTH) + 1;

  uart_reg_e   reg_sel;
  logic        wr, rd, flush, pop;

  logic        enable_q, enable_d;
  logic        snum_q, snum_d;
  logic        irq_en_q, irq_en_d;
  logic        overrun_q, overrun_d;
  logic        irq_q, irq_d;
  logic        rx_done_q;
  logic        push_q, push_d;
  logic [7:0]  rx_byte_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] status_word, ctrl_word;

  logic [7:0]    fifo_head;
  logic          fifo_empty, fifo_full, fifo_drop;
  logic [CW-1:0] fifo_count, fifo_count_next;

  assign reg_sel = uart_reg_e'(addr);
  assign wr      = sel & we;
  assign rd      = sel & ~we;
  assign flush   = wr & (reg_sel == REG_CTRL) & wdata[CTRL_FLUSH_BIT];
  assign pop     = rd & (reg_sel == REG_DATA);

  uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push_q),
    .data_i       (rx_byte_q),
    .pop_i        (pop),
    .flush_i      (flush),
    .head_o       (fifo_head),
    .empty_o      (fifo_empty),
    .full_o       (fifo_full),
    .count_o      (fifo_count),
    .count_next_o (fifo_count_next),
    .drop_o       (fifo_drop)
  );

  always_comb begin
    status_word = '0;
    status_word[STAT_NOT_EMPTY_BIT]       = ~fifo_empty;
    status_word[STAT_FULL_BIT]            = fifo_full;
    status_word[STAT_OVERRUN_BIT]         = overrun_q;
    status_word[STAT_RXING_BIT]           = rxing;
    status_word[STAT_COUNT_LSB +: CW]     = fifo_count;
    ctrl_word = '0;
    ctrl_word[CTRL_EN_BIT]     = enable_q;
    ctrl_word[CTRL_SNUM_BIT]   = snum_q;
    ctrl_word[CTRL_IRQ_EN_BIT] = irq_en_q;
  end

  always_comb begin
    enable_d  = enable_q;
    snum_d    = snum_q;
    irq_en_d  = irq_en_q;
    div_d     = div_q;
    overrun_d = overrun_q;
    rdata_d   = rdata_q;

    if (wr && reg_sel == REG_CTRL) begin
      enable_d = wdata[CTRL_EN_BIT];
      snum_d   = wdata[CTRL_SNUM_BIT];
      irq_en_d = wdata[CTRL_IRQ_EN_BIT];
    end
    if (wr && reg_sel == REG_DIV) div_d = wdata[DIV_W-1:0];
    if (wr && reg_sel == REG_STATUS && wdata[STAT_OVERRUN_BIT]) overrun_d = 1'b0;
    // A drop in the same cycle as a clear wins, so no lost byte goes unreported.
    if (fifo_drop) overrun_d = 1'b1;

    if (rd) begin
      unique case (reg_sel)
        REG_DATA:   rdata_d = fifo_empty ? '0 : 32'({1'b1, fifo_head});
        REG_STATUS: rdata_d = status_word;
        REG_CTRL:   rdata_d = ctrl_word;
        REG_DIV:    rdata_d = 32'(div_q);
        default:    rdata_d = '0;
      endcase
    end

    if (wr && reg_sel == REG_DIV)  cnt_d = '0;
    else if (!enable_q)            cnt_d = '0;
    else if (cnt_q >= div_q)       cnt_d = '0;
    else                           cnt_d = cnt_q + DIV_W'(1);

    push_d = rx_done & ~rx_done_q & enable_q;
    irq_d  = irq_en_d & ((fifo_count_next != '0) | overrun_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q  <= 1'b0;
      snum_q    <= 1'b0;
      irq_en_q  <= 1'b0;
      overrun_q <= 1'b0;
      irq_q     <= 1'b0;
      rx_done_q <= 1'b0;
      push_q    <= 1'b0;
      rx_byte_q <= '0;
      div_q     <= DIV_W'(DIV_RESET);
      cnt_q     <= '0;
      rdata_q   <= '0;
    end else begin
      enable_q  <= enable_d;
      snum_q    <= snum_d;
      irq_en_q  <= irq_en_d;
      overrun_q <= overrun_d;
      irq_q     <= irq_d;
      rx_done_q <= rx_done;
      push_q    <= push_d;
      rx_byte_q <= d_rx;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
    end
  end

  assign tick  = enable_q & (cnt_q == div_q);
  assign snum  = snum_q;
  assign irq   = irq_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a byte scoreboard for DATA reads.
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel, we;
  logic [1:0]  addr;
  logic [31:0] wdata, rdata;
  logic [7:0]  d_rx;
  logic        rx_done, rxing;
  logic        tick, snum, irq;

  int errors = 0;
  int checks = 0;
  logic [7:0] sb[$];
  bit en_model = 1'b0;

  uart_rx_ctrl #(.DEPTH(8), .DIV_W(16), .DIV_RESET(26)) dut (
    .clk     (clk),
    .reset   (reset),
    .sel     (sel),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .d_rx    (d_rx),
    .rx_done (rx_done),
    .rxing   (rxing),
    .tick    (tick),
    .snum    (snum),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    cyc;
    sel = 1'b0; we = 1'b0; wdata = '0;
    if (a == 2'd2) en_model = d[0];
    $display("wr addr=%0d data=%h", a, d);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    sel = 1'b1; we = 1'b0; addr = a;
    cyc;
    sel = 1'b0;
    d = rdata;
    $display("rd addr=%0d data=%h", a, d);
  endtask

  task automatic read_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus_read(a, v);
    check(tag, v, exp);
  endtask

  task automatic read_data(input string tag);
    logic [31:0] v, exp;
    bus_read(2'd0, v);
    if (sb.size() != 0) exp = 32'h100 | 32'(sb.pop_front());
    else exp = 32'h0;
    check(tag, v, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    d_rx = b; rx_done = 1'b1;
    repeat (hold) cyc;
    rx_done = 1'b0;
    cyc;
    if (en_model && sb.size() < 8) sb.push_back(b);
    $display("rx byte=%h hold=%0d", b, hold);
  endtask

  initial begin
    logic [15:0] tv;
    logic [7:0]  tv0;
    logic [31:0] v, exp;
    int nt;

    reset = 1'b1; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    d_rx = '0; rx_done = 1'b0; rxing = 1'b0;
    repeat (3) cyc;
    reset = 1'b0;

    // Reset state
    check("rst_rdata", rdata, 32'h0);
    check("rst_tick", {31'b0, tick}, 32'h0);
    check("rst_snum", {31'b0, snum}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    read_reg("rst_data", 2'd0, 32'h0);
    read_reg("rst_status", 2'd1, 32'h0);
    read_reg("rst_ctrl", 2'd2, 32'h0);
    read_reg("rst_div", 2'd3, 32'd26);
    rxing = 1'b1;
    read_reg("status_rxing", 2'd1, 32'h8);
    rxing = 1'b0;
    nt = 0;
    for (int i = 0; i < 100; i++) begin
      nt += int'(tick);
      cyc;
    end
    check("tick_disabled", nt, 0);
    send_byte(8'h99, 3);
    read_reg("push_disabled", 2'd1, 32'h0);

    // Baud tick
    bus_write(2'd3, 32'd3);
    bus_write(2'd2, 32'h1);
    tv = '0;
    for (int i = 0; i < 16; i++) begin
      tv[i] = tick;
      cyc;
    end
    check("tick_div3", 32'(tv), 32'h8888);
    cyc;
    bus_write(2'd3, 32'd0);
    tv0 = '0;
    for (int i = 0; i < 8; i++) begin
      tv0[i] = tick;
      cyc;
    end
    check("tick_div0", 32'(tv0), 32'hFF);
    bus_write(2'd3, 32'd26);

    // Two bytes, push latency of two cycles
    d_rx = 8'hA5; rx_done = 1'b1;
    cyc;
    read_reg("latency_1cyc", 2'd1, 32'h0);
    read_reg("latency_2cyc", 2'd1, 32'h101);
    repeat (2) cyc;
    rx_done = 1'b0;
    cyc;
    sb.push_back(8'hA5);
    send_byte(8'h3C, 5);
    read_reg("count_two", 2'd1, 32'h201);
    read_data("data_a5");
    read_data("data_3c");
    read_data("data_empty");

    // Overflow
    for (int i = 0; i < 9; i++) send_byte(8'(i), 1);
    read_reg("status_ovr", 2'd1, 32'h807);
    for (int i = 0; i < 8; i++) read_data("data_ovr");
    read_reg("status_ovr_empty", 2'd1, 32'h4);
    bus_write(2'd1, 32'h4);
    read_reg("status_ovr_clr", 2'd1, 32'h0);

    // Push and pop in the same cycle while full
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 1);
    d_rx = 8'h55; rx_done = 1'b1;
    cyc;
    bus_read(2'd0, v);
    rx_done = 1'b0;
    exp = 32'h100 | 32'(sb.pop_front());
    sb.push_back(8'h55);
    check("full_pushpop", v, exp);
    cyc;
    read_reg("full_pushpop_status", 2'd1, 32'h803);
    for (int i = 0; i < 8; i++) read_data("drain_full");
    read_reg("drain_status", 2'd1, 32'h0);

    // Interrupt and flush
    bus_write(2'd2, 32'h5);
    check("irq_idle", {31'b0, irq}, 32'h0);
    send_byte(8'h77, 2);
    check("irq_set", {31'b0, irq}, 32'h1);
    read_data("irq_byte");
    check("irq_clr", {31'b0, irq}, 32'h0);
    for (int i = 0; i < 3; i++) send_byte(8'hC0 + 8'(i), 2);
    read_reg("pre_flush", 2'd1, 32'h301);
    check("irq_pre_flush", {31'b0, irq}, 32'h1);
    bus_write(2'd2, 32'hD);
    sb.delete();
    check("irq_flush", {31'b0, irq}, 32'h0);
    read_reg("post_flush", 2'd1, 32'h0);
    read_reg("ctrl_flush_rd0", 2'd2, 32'h5);

    // Reset mid-stream
    bus_write(2'd2, 32'h7);
    check("snum_set", {31'b0, snum}, 32'h1);
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    check("irq_before_rst", {31'b0, irq}, 32'h1);
    bus_write(2'd3, 32'd5);
    reset = 1'b1;
    cyc;
    reset = 1'b0;
    sb.delete();
    en_model = 1'b0;
    check("mid_rst_rdata", rdata, 32'h0);
    check("mid_rst_irq", {31'b0, irq}, 32'h0);
    check("mid_rst_snum", {31'b0, snum}, 32'h0);
    check("mid_rst_tick", {31'b0, tick}, 32'h0);
    read_reg("mid_rst_status", 2'd1, 32'h0);
    read_reg("mid_rst_ctrl", 2'd2, 32'h0);
    read_reg("mid_rst_div", 2'd3, 32'd26);
    read_data("mid_rst_data");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
